// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle, with valid/ready handshakes on the request and result sides.
module div_iter #(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                div_valid,
  output logic                div_ready,
  input  logic                div_signed,
  input  logic [DATA_LEN-1:0] dividend,
  input  logic [DATA_LEN-1:0] divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder
);

  localparam int unsigned CW  = $clog2(DATA_LEN);
  localparam int unsigned TW  = DATA_LEN + 1;
  localparam int unsigned MSB = DATA_LEN - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CW-1:0]       r_cnt;
  logic [DATA_LEN-1:0] r_rem;
  logic [DATA_LEN-1:0] r_quo;
  logic [DATA_LEN-1:0] r_div_mag;
  logic                r_sign_q;
  logic                r_sign_r;
  logic [DATA_LEN-1:0] r_quotient;
  logic [DATA_LEN-1:0] r_remainder;

  logic                w_accept;
  logic                w_dvd_neg;
  logic                w_dvs_neg;
  logic [DATA_LEN-1:0] w_dvd_mag;
  logic [DATA_LEN-1:0] w_dvs_mag;
  logic                w_div_zero;
  logic                w_overflow;
  logic                w_special;
  logic [TW-1:0]       w_trial;
  logic [DATA_LEN-1:0] w_rem_nxt;
  logic [DATA_LEN-1:0] w_quo_nxt;

  assign div_ready = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

  // Operand decode for the acceptance cycle: magnitudes and the two short-circuit cases
  assign w_accept   = div_ready & div_valid & ~flush;
  assign w_dvd_neg  = div_signed & dividend[MSB];
  assign w_dvs_neg  = div_signed & divisor[MSB];
  assign w_dvd_mag  = w_dvd_neg ? (~dividend + DATA_LEN'(1)) : dividend;
  assign w_dvs_mag  = w_dvs_neg ? (~divisor + DATA_LEN'(1)) : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_overflow = div_signed & (dividend == {1'b1, {(DATA_LEN-1){1'b0}}}) & (divisor == '1);
  assign w_special  = w_div_zero | w_overflow;

  // Trial subtraction as an add of the inverted, zero-extended divisor with carry-in 1
  assign w_trial   = {r_rem, r_quo[MSB]} + ~{1'b0, r_div_mag} + TW'(1);
  assign w_rem_nxt = w_trial[TW-1] ? {r_rem[MSB-1:0], r_quo[MSB]} : w_trial[DATA_LEN-1:0];
  assign w_quo_nxt = {r_quo[MSB-1:0], ~w_trial[TW-1]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (div_valid) w_next_state = w_special ? DONE : CALC;
      CALC:    if (r_cnt == '0) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (flush) w_next_state = IDLE;
  end

  // Datapath: capture on accept, one restoring step per CALC cycle, sign fix-up on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div_mag   <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        r_sign_q  <= w_dvd_neg ^ w_dvs_neg;
        r_sign_r  <= w_dvd_neg;
        r_rem     <= '0;
        r_quo     <= w_dvd_mag;
        r_div_mag <= w_dvs_mag;
        r_cnt     <= CW'(DATA_LEN - 1);
        if (w_div_zero) begin
          r_quotient  <= '1;
          r_remainder <= dividend;
        end else if (w_overflow) begin
          r_quotient  <= dividend;
          r_remainder <= '0;
        end
      end else if (r_state == CALC) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == '0) begin
          r_quotient  <= r_sign_q ? (~w_quo_nxt + DATA_LEN'(1)) : w_quo_nxt;
          r_remainder <= r_sign_r ? (~w_rem_nxt + DATA_LEN'(1)) : w_rem_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus random operands
// checked against a plain-arithmetic reference model.
module tb_div_iter;

  localparam int unsigned DL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          div_valid;
  logic          div_ready;
  logic          div_signed;
  logic [DL-1:0] dividend;
  logic [DL-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DL-1:0] quotient;
  logic [DL-1:0] remainder;

  int n_vec = 0;
  int n_err = 0;

  div_iter #(.DATA_LEN(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V division semantics from plain arithmetic
  function automatic void model(input logic [DL-1:0] a, input logic [DL-1:0] b, input logic s,
                                output logic [DL-1:0] q, output logic [DL-1:0] r, output int lat);
    if (b == 0) begin
      q = '1; r = a; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; lat = 1;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
      lat = DL + 1;
    end else begin
      q = a / b; r = a % b; lat = DL + 1;
    end
  endfunction

  // Issue one op, measure latency, hold out_ready low for 'hold' cycles, then
  // handshake while presenting a stray request that must not be accepted.
  task automatic do_op(input logic [DL-1:0] a, input logic [DL-1:0] b, input logic s, input int hold);
    logic [DL-1:0] eq, er;
    int elat, lat;
    model(a, b, s, eq, er, elat);
    @(negedge clk);
    chk("ready_before_accept", {31'b0, div_ready}, 32'd1);
    dividend = a; divisor = b; div_signed = s; div_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    div_valid = 1'b0; dividend = $urandom; divisor = $urandom; div_signed = 1'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    chk("latency", 32'(lat), 32'(elat));
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
    end
    out_ready = 1'b1; div_valid = 1'b1; dividend = 32'd50; divisor = 32'd5; div_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; div_valid = 1'b0;
    chk("post_hs_valid", {31'b0, out_valid}, 32'd0);
    chk("post_hs_ready", {31'b0, div_ready}, 32'd1);
  endtask

  initial begin
    logic seen;
    logic [DL-1:0] ra, rb;
    rst = 1'b1; flush = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, div_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    rst = 1'b0;

    do_op(32'd100, 32'd7, 1'b0, 0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    do_op(32'h0000_1234, 32'd0, 1'b0, 2);
    do_op(32'h0000_1234, 32'd0, 1'b1, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(32'd100, 32'd7, 1'b0, 7);

    // Flush mid-CALC, re-accept, then reset mid-CALC: neither op may complete
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; div_signed = 1'b0; div_valid = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= out_valid;
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_to_idle", {31'b0, div_ready}, 32'd1);
    dividend = 32'd1000; divisor = 32'd3; div_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
    chk("second_op_busy", {31'b0, div_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_ready", {31'b0, div_ready}, 32'd1);
    chk("rst2_quotient", quotient, 32'd0);
    chk("rst2_remainder", remainder, 32'd0);
    repeat (40) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("flushed_never_valid", {31'b0, seen}, 32'd0);
    do_op(32'd100, 32'd7, 1'b0, 0);

    // Flush in IDLE with a request present must not accept
    @(negedge clk);
    flush = 1'b1; div_valid = 1'b1; dividend = 32'd9; divisor = 32'd0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; div_valid = 1'b0;
    chk("flush_blocks_accept", {31'b0, div_ready}, 32'd1);
    chk("flush_blocks_valid", {31'b0, out_valid}, 32'd0);

    // Flush while a result is waiting discards it
    @(negedge clk);
    dividend = 32'd5; divisor = 32'd0; div_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
    chk("special_done", {31'b0, out_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_done_ready", {31'b0, div_ready}, 32'd1);

    // Random operands, with occasional forced corner divisors
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
